mul_int_arb: RTL

- Shares one fixed-latency pipelined integer multiplier datapath (Wallace-tree core plus final adder) between two requesters.
- Performs round-robin arbitration and tracks in-flight ops with a valid/id/tag shadow pipeline.
- Returns each product to its originating requester through a one-entry response buffer per requester.
- Applies global backpressure (mul_stall) to the datapath when a response cannot be delivered.

---
 rtl/mul_int_arb.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mul_int_arb.sv
// -----------------------------------------------------------------------------
// mul_int_arb
//
// Purpose:
//   Lets two requesters share one external fixed-latency pipelined integer
//   multiplier. Each cycle a round-robin arbiter issues at most one request.
//   A {valid, id, tag} shadow pipeline runs alongside the datapath, so the
//   product can be routed back to the requester that issued it. Each requester
//   has a one-entry response buffer. If a product reaches the exit stage while
//   its buffer is still occupied and not being drained, the whole datapath is
//   stalled.
//
// Parameters:
//   WIDTH  operand width in bits
//   LAT    datapath latency, issue -> mul_res valid (>= 1)
//   TAG_W  width of the opaque requester tag
//
// Ports:
//   clock, resetn                 clock and asynchronous active-low reset
//   reqN_valid/ready              request handshake, N = 0,1
//   reqN_a/b/signed/tag           request operands, signedness, tag
//   mul_valid/a/b/signed          issue interface towards the datapath
//   mul_stall                     datapath pipeline hold (combinational)
//   mul_res                       datapath product, aligned with exit stage
//   rspN_valid/ready/res/tag      response handshake and payload, N = 0,1
//   perf_issue_cnt/stall_cnt      performance counters
//
// Optional feature:
//   Defining the macro MUL_ARB_PERF_EN builds the two 32-bit wrapping
//   performance counters. When the macro is not defined, both counter ports
//   are tied to zero.
// -----------------------------------------------------------------------------
module mul_int_arb #(
    parameter int WIDTH = 32,
    parameter int LAT   = 2,
    parameter int TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 resetn,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req0_signed,
    input  logic [TAG_W-1:0]     req0_tag,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic                 req1_signed,
    input  logic [TAG_W-1:0]     req1_tag,

    output logic                 mul_valid,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 mul_signed,
    output logic                 mul_stall,
    input  logic [2*WIDTH-1:0]   mul_res,

    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_res,
    output logic [TAG_W-1:0]     rsp0_tag,

    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_res,
    output logic [TAG_W-1:0]     rsp1_tag,

    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
);

    // Requester-indexed views of the response ports
    logic [1:0]              rsp_ready_w;
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};

    // Shadow pipeline. Index LAT is the exit slot; it is aligned with mul_res.
    logic [LAT:1]            vld_q;
    logic [LAT:1]            id_q;
    logic [TAG_W-1:0]        stag_q [1:LAT];

    logic                    exit_vld;
    logic                    exit_id;
    logic [TAG_W-1:0]        exit_tag;
    assign exit_vld = vld_q[LAT];
    assign exit_id  = id_q[LAT];
    assign exit_tag = stag_q[LAT];

    // One-entry response buffers
    logic [1:0]              full_q;
    logic [2*WIDTH-1:0]      bres_q [2];
    logic [TAG_W-1:0]        btag_q [2];

    // Stall: the op at the exit slot has nowhere to go this cycle.
    logic                    stall;
    assign stall     = exit_vld & full_q[exit_id] & ~rsp_ready_w[exit_id];
    assign mul_stall = stall;

    // ------------------------------------------------------------------
    // Round-robin arbitration. ptr_q names the requester that wins a tie.
    // Grants are also gated by resetn, so ready and issue stay low while
    // reset is asserted, even if a requester is already driving valid.
    // ------------------------------------------------------------------
    logic                    ptr_q, ptr_d;
    logic                    gnt0, gnt1, grant_any;
    logic [TAG_W-1:0]        grant_tag;

    assign gnt0      = resetn & ~stall & req0_valid & (~req1_valid | ~ptr_q);
    assign gnt1      = resetn & ~stall & req1_valid & (~req0_valid |  ptr_q);
    assign grant_any = gnt0 | gnt1;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        mul_valid  = grant_any;
        mul_a      = '0;
        mul_b      = '0;
        mul_signed = 1'b0;
        grant_tag  = '0;
        ptr_d      = ptr_q;
        if (gnt0) begin
            mul_a      = req0_a;
            mul_b      = req0_b;
            mul_signed = req0_signed;
            grant_tag  = req0_tag;
            ptr_d      = 1'b1;
        end else if (gnt1) begin
            mul_a      = req1_a;
            mul_b      = req1_b;
            mul_signed = req1_signed;
            grant_tag  = req1_tag;
            ptr_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow pipeline: advances only when not stalled, in lock step with
    // the datapath registers. The id of a stage is 1 when requester 1 was
    // granted.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_q[1]  <= 1'b0;
            id_q[1]   <= 1'b0;
            stag_q[1] <= '0;
        end else if (!stall) begin
            vld_q[1]  <= grant_any;
            id_q[1]   <= gnt1;
            stag_q[1] <= grant_tag;
        end
    end

    genvar gi;
    generate
        for (gi = 2; gi <= LAT; gi++) begin : g_stage
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    vld_q[gi]  <= 1'b0;
                    id_q[gi]   <= 1'b0;
                    stag_q[gi] <= '0;
                end else if (!stall) begin
                    vld_q[gi]  <= vld_q[gi-1];
                    id_q[gi]   <= id_q[gi-1];
                    stag_q[gi] <= stag_q[gi-1];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response buffers. Drain and reload can happen on the same edge; in
    // that case the buffer stays full and takes the new product.
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic load;
            logic full_d;

            assign load   = exit_vld & ~stall & (exit_id == 1'(gi));
            assign full_d = load | (full_q[gi] & ~rsp_ready_w[gi]);

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    full_q[gi] <= 1'b0;
                    bres_q[gi] <= '0;
                    btag_q[gi] <= '0;
                end else begin
                    full_q[gi] <= full_d;
                    if (load) begin
                        bres_q[gi] <= mul_res;
                        btag_q[gi] <= exit_tag;
                    end
                end
            end
        end
    endgenerate

    assign rsp0_valid = full_q[0];
    assign rsp0_res   = bres_q[0];
    assign rsp0_tag   = btag_q[0];
    assign rsp1_valid = full_q[1];
    assign rsp1_res   = bres_q[1];
    assign rsp1_tag   = btag_q[1];

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef MUL_ARB_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // mul_valid already implies ~stall, because grants are stall-gated.
    assign perf_issue_d = perf_issue_q + 32'(mul_valid);
    assign perf_stall_d = perf_stall_q + 32'(stall);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule
